// File: rtl/text_render_ctrl.sv
// text_render_ctrl: three-stage text-mode pixel pipeline for an 80x30
// character display (640x480, 8x16 glyphs).
//
// Stage 1 turns the pixel coordinate into a text-buffer cell address and
// evaluates the cursor position. Stage 2 captures the character code and
// attribute returned by the text RAM and presents code/row to the glyph
// ROM. Stage 3 picks the glyph bit, applies reverse video and the blinking
// underline cursor, and registers the final colour. The syncs travel with
// the pixel, so rgb, hsync_out and vsync_out stay aligned.
//
// Ports:
//   clk, reset          system clock, async active-high reset
//   pixel_tick          pixel enable; every pipeline register loads on it
//   pixel_x, pixel_y    pixel coordinate from the timing generator
//   video_on            visible-area flag
//   hsync_in, vsync_in  active-low syncs from the timing generator
//   cursor_en           cursor display enable
//   cursor_col/_row     cursor cell position
//   tb_addr, tb_data    text RAM read port (data valid 1 clk after addr)
//   char_code           glyph ROM character code
//   glyph_row           glyph ROM row within the 8x16 cell
//   char_line           glyph ROM data, bit 7 is the leftmost pixel
//   rgb                 12-bit pixel colour
//   hsync_out/vsync_out syncs delayed to match rgb

module text_render_ctrl #(
    parameter int          COLS         = 80,
    parameter int          ROWS         = 30,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] FG_RGB       = 12'hFFF,
    parameter logic [11:0] BG_RGB       = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_tick,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [11:0] tb_addr,
    input  logic [7:0]  tb_data,
    output logic [6:0]  char_code,
    output logic [3:0]  glyph_row,
    input  logic [7:0]  char_line,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    // One extra bit of headroom so BLINK_FRAMES=1 still gets a valid width.
    localparam int FW = $clog2(BLINK_FRAMES) + 1;

    localparam logic [FW-1:0] LAST_FRAME = FW'(BLINK_FRAMES - 1);
    localparam logic [11:0]   COLS_W     = 12'(COLS);
    localparam logic [6:0]    COLS_7     = 7'(COLS);
    localparam logic [4:0]    ROWS_5     = 5'(ROWS);

    // ------------------------------------------------------------
    // Cell coordinate of the incoming pixel
    // ------------------------------------------------------------
    logic [6:0]  cell_col;
    logic [4:0]  cell_row;
    logic [3:0]  line_in_cell;
    logic [11:0] addr_next;
    logic        col_ok;
    logic        row_ok;
    logic        cursor_next;

    // pixel_y[9] is beyond the 480-line screen and never addresses text.
    logic        unused_y9;

    assign cell_col     = pixel_x[9:3];
    assign cell_row     = pixel_y[8:4];
    assign line_in_cell = pixel_y[3:0];
    assign unused_y9    = pixel_y[9];

    assign addr_next = {7'd0, cell_row} * COLS_W
                     + {5'd0, cell_col};

    // An out-of-range cursor position must never match, even though
    // pixel_x can reach cell columns past the visible area.
    assign col_ok = (cursor_col < COLS_7);
    assign row_ok = (cursor_row < ROWS_5);

    // Underline cursor: bottom two scan lines of the cursor cell.
    assign cursor_next = cursor_en
                       & col_ok
                       & row_ok
                       & (cell_col == cursor_col)
                       & (cell_row == cursor_row)
                       & (line_in_cell >= 4'd14);

    // ------------------------------------------------------------
    // Stage 1: address generation and side-band delay
    // ------------------------------------------------------------
    logic [2:0] s1_x;
    logic [3:0] s1_y;
    logic       s1_von;
    logic       s1_hs;
    logic       s1_vs;
    logic       s1_cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tb_addr <= 12'd0;
            s1_x    <= 3'd0;
            s1_y    <= 4'd0;
            s1_von  <= 1'b0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
            s1_cur  <= 1'b0;
        end else if (pixel_tick) begin
            tb_addr <= video_on ? addr_next : 12'd0;
            s1_x    <= pixel_x[2:0];
            s1_y    <= line_in_cell;
            s1_von  <= video_on;
            s1_hs   <= hsync_in;
            s1_vs   <= vsync_in;
            s1_cur  <= cursor_next;
        end
    end

    // ------------------------------------------------------------
    // Stage 2: character fetch, glyph ROM addressing
    // ------------------------------------------------------------
    logic       s2_rev;
    logic [2:0] s2_x;
    logic       s2_von;
    logic       s2_hs;
    logic       s2_vs;
    logic       s2_cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            char_code <= 7'd0;
            glyph_row <= 4'd0;
            s2_rev    <= 1'b0;
            s2_x      <= 3'd0;
            s2_von    <= 1'b0;
            s2_hs     <= 1'b1;
            s2_vs     <= 1'b1;
            s2_cur    <= 1'b0;
        end else if (pixel_tick) begin
            char_code <= tb_data[6:0];
            glyph_row <= s1_y;
            s2_rev    <= tb_data[7];
            s2_x      <= s1_x;
            s2_von    <= s1_von;
            s2_hs     <= s1_hs;
            s2_vs     <= s1_vs;
            s2_cur    <= s1_cur;
        end
    end

    // ------------------------------------------------------------
    // Cursor blink: counts falling edges of the stage-1 vsync copy
    // ------------------------------------------------------------
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic          vs_fall;

    assign vs_fall = s1_vs & ~vsync_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (pixel_tick && vs_fall) begin
            if (frame_cnt == LAST_FRAME) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------
    // Stage 3: pixel select and colour
    // ------------------------------------------------------------
    logic glyph_bit;
    logic pix_on;

    // x=0 is the leftmost pixel, which the ROM places in bit 7.
    assign glyph_bit = char_line[3'd7 - s2_x];
    assign pix_on    = glyph_bit
                     ^ s2_rev
                     ^ (s2_cur & blink_phase);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb       <= 12'h000;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else if (pixel_tick) begin
            if (s2_von) begin
                rgb <= pix_on ? FG_RGB : BG_RGB;
            end else begin
                rgb <= 12'h000;
            end
            hsync_out <= s2_hs;
            vsync_out <= s2_vs;
        end
    end

endmodule

// File: tb/tb_text_render_ctrl.sv
// tb_text_render_ctrl: self-checking bench for text_render_ctrl with a
// text RAM model, a glyph ROM model and an output scoreboard.

module tb_text_render_ctrl;

    localparam int BF = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        pixel_tick;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [11:0] tb_addr;
    logic [7:0]  tb_data = 8'h00;
    logic [6:0]  char_code;
    logic [3:0]  glyph_row;
    logic [7:0]  char_line;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;

    text_render_ctrl #(
        .COLS(80), .ROWS(30), .BLINK_FRAMES(BF),
        .FG_RGB(12'hFFF), .BG_RGB(12'h000)
    ) dut (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .cursor_en(cursor_en),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .tb_addr(tb_addr), .tb_data(tb_data),
        .char_code(char_code), .glyph_row(glyph_row),
        .char_line(char_line),
        .rgb(rgb),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    // Text RAM: registered read, data valid one clk after address.
    logic [7:0] txt [0:4095];
    always @(posedge clk) tb_data <= txt[tb_addr];

    // Glyph ROM: zero outside 32..126; 'A' is a centred bar.
    function automatic logic [7:0] rom(input logic [6:0] c,
                                       input logic [3:0] r);
        if (c < 7'd32 || c > 7'd126) return 8'h00;
        if (c == 7'h41) return 8'b0001_1000;
        return {c[3:0], r};
    endfunction

    assign char_line = rom(char_code, glyph_row);

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int hs_low = 0;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        von;
        logic        cen;
        logic [6:0]  ccol;
        logic [4:0]  crow;
        logic [11:0] rgb;
        string       nm;
    } vec_t;

    vec_t tv[17];

    task automatic chk(input string nm,
                       input logic [11:0] got,
                       input logic [11:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic tick_once();
        @(negedge clk) pixel_tick = 1'b1;
        @(negedge clk) pixel_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic apply(input logic [9:0] x, input logic [9:0] y,
                         input logic von, input logic hs,
                         input logic vs, input logic [11:0] e,
                         input string nm);
        exp_t ex;
        pixel_x  = x;
        pixel_y  = y;
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        ex.rgb = e;
        ex.hs  = hs;
        ex.vs  = vs;
        sbq.push_back(ex);
        tick_once();
        n_cmp++;
        if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            ex = sbq.pop_front();
            if (rgb !== ex.rgb || hsync_out !== ex.hs
                || vsync_out !== ex.vs) begin
                n_bad++;
                $display("FAIL %s: got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                         nm, rgb, hsync_out, vsync_out,
                         ex.rgb, ex.hs, ex.vs);
            end
        end
        if (!hsync_out) hs_low++;
    endtask

    task automatic idle(input string nm);
        apply(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, nm);
    endtask

    task automatic prefill();
        exp_t ex;
        sbq.delete();
        ex.rgb = 12'h000;
        ex.hs  = 1'b1;
        ex.vs  = 1'b1;
        repeat (2) sbq.push_back(ex);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        pixel_tick = 1'b0;
        pixel_x    = '0;
        pixel_y    = '0;
        video_on   = 1'b0;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        prefill();
    endtask

    task automatic cur_px(input logic [11:0] e, input string nm);
        apply(10'd17, 10'd46, 1'b1, 1'b1, 1'b1, e, nm);
        idle("pad");
    endtask

    task automatic falls(input int n);
        for (int i = 0; i < n; i++) begin
            apply(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 12'h000, "vs_lo");
            apply(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000, "vs_hi");
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) txt[i] = 8'h20;
        txt[0]   = 8'h05;
        txt[1]   = 8'h85;
        txt[162] = 8'h41;
        txt[163] = 8'hC1;
        txt[164] = 8'h4A;

        tv[0]  = '{10'd19,  10'd35,  1, 0, 7'd2,  5'd2,  12'hFFF, "a_on"};
        tv[1]  = '{10'd16,  10'd35,  1, 0, 7'd2,  5'd2,  12'h000, "a_off"};
        tv[2]  = '{10'd27,  10'd35,  1, 0, 7'd2,  5'd2,  12'h000, "rev_on"};
        tv[3]  = '{10'd24,  10'd35,  1, 0, 7'd2,  5'd2,  12'hFFF, "rev_off"};
        tv[4]  = '{10'd3,   10'd0,   1, 0, 7'd2,  5'd2,  12'h000, "bad_code"};
        tv[5]  = '{10'd8,   10'd5,   1, 0, 7'd2,  5'd2,  12'hFFF, "bad_rev"};
        tv[6]  = '{10'd19,  10'd35,  0, 0, 7'd2,  5'd2,  12'h000, "blanked"};
        tv[7]  = '{10'd100, 10'd100, 1, 0, 7'd2,  5'd2,  12'h000, "space"};
        tv[8]  = '{10'd17,  10'd46,  1, 1, 7'd2,  5'd2,  12'hFFF, "cur46"};
        tv[9]  = '{10'd20,  10'd47,  1, 1, 7'd2,  5'd2,  12'h000, "cur47_inv"};
        tv[10] = '{10'd17,  10'd45,  1, 1, 7'd2,  5'd2,  12'h000, "cur45"};
        tv[11] = '{10'd17,  10'd46,  1, 0, 7'd2,  5'd2,  12'h000, "cur_dis"};
        tv[12] = '{10'd640, 10'd46,  1, 1, 7'd80, 5'd2,  12'h000, "col_oob"};
        tv[13] = '{10'd17,  10'd510, 1, 1, 7'd2,  5'd31, 12'h000, "row_oob"};
        tv[14] = '{10'd32,  10'd35,  1, 0, 7'd2,  5'd2,  12'hFFF, "j_b7"};
        tv[15] = '{10'd33,  10'd35,  1, 0, 7'd2,  5'd2,  12'h000, "j_b6"};
        tv[16] = '{10'd20,  10'd38,  1, 1, 7'd2,  5'd2,  12'hFFF, "a_r6"};

        cursor_en  = 1'b0;
        cursor_col = 7'd2;
        cursor_row = 5'd2;
        do_reset();

        chk("rst_rgb",   rgb, 12'h000);
        chk("rst_hs",    {11'd0, hsync_out}, 12'd1);
        chk("rst_vs",    {11'd0, vsync_out}, 12'd1);
        chk("rst_addr",  tb_addr, 12'd0);
        chk("rst_code",  {5'd0, char_code}, 12'd0);
        chk("rst_row",   {8'd0, glyph_row}, 12'd0);
        idle("idle0");
        idle("idle1");
        idle("idle2");

        apply(10'd17, 10'd35, 1'b1, 1'b1, 1'b1, 12'h000, "addr_px");
        chk("tb_addr", tb_addr, 12'd162);
        idle("addr_nx");
        chk("char_code", {5'd0, char_code}, 12'h041);
        chk("glyph_row", {8'd0, glyph_row}, 12'd3);
        idle("addr_p2");

        for (int i = 0; i < 17; i++) begin
            cursor_en  = tv[i].cen;
            cursor_col = tv[i].ccol;
            cursor_row = tv[i].crow;
            apply(tv[i].x, tv[i].y, tv[i].von, 1'b1, 1'b1,
                  tv[i].rgb, tv[i].nm);
        end
        cursor_en  = 1'b0;
        cursor_col = 7'd2;
        cursor_row = 5'd2;
        idle("drain0");
        idle("drain1");

        hs_low = 0;
        for (int i = 0; i < 96; i++)
            apply(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 12'h000, "hs_pulse");
        for (int i = 0; i < 4; i++)
            idle("hs_tail");
        chk("hs_width", 12'(hs_low), 12'd96);

        apply(10'd19, 10'd35, 1'b1, 1'b1, 1'b1, 12'hFFF, "frz_px");
        idle("frz_a");
        idle("frz_b");
        pixel_x  = 10'd24;
        pixel_y  = 10'd35;
        video_on = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        repeat (20) @(negedge clk);
        chk("frz_rgb",  rgb, 12'hFFF);
        chk("frz_addr", tb_addr, 12'd0);
        chk("frz_hs",   {11'd0, hsync_out}, 12'd1);

        for (int i = 0; i < 3; i++)
            apply(10'd19, 10'd35, 1'b1, 1'b0, 1'b1, 12'hFFF, "pre_rst");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_rgb",  rgb, 12'h000);
        chk("arst_hs",   {11'd0, hsync_out}, 12'd1);
        chk("arst_addr", tb_addr, 12'd0);
        chk("arst_code", {5'd0, char_code}, 12'd0);
        do_reset();
        apply(10'd19, 10'd35, 1'b1, 1'b1, 1'b1, 12'hFFF, "post_px");
        idle("post_a");
        chk("post_early", rgb, 12'h000);
        idle("post_b");
        chk("post_valid", rgb, 12'hFFF);

        do_reset();
        cursor_en = 1'b1;
        cur_px(12'hFFF, "blink_0");
        falls(BF - 1);
        cur_px(12'hFFF, "blink_29");
        falls(1);
        cur_px(12'h000, "blink_30");
        cursor_en = 1'b0;
        falls(BF);
        cur_px(12'h000, "blink_dis");
        cursor_en = 1'b1;
        cur_px(12'hFFF, "blink_60");
        apply(10'd17, 10'd45, 1'b1, 1'b1, 1'b1, 12'h000, "blink_r45");
        idle("end0");
        idle("end1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
